// File: rtl/or_input_debouncer.sv
// Two-channel synchronizer/debouncer feeding the a and b inputs of a two-input OR gate.
// Each channel filters its raw asynchronous input and emits registered level and edge pulses.

module or_input_debouncer_channel #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // A new level is accepted only after s2 has disagreed with it for STABLE_CYCLES
    // consecutive edges; any return to the current level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST_COUNT) begin
                level <= s2;
                cnt   <= '0;
                rise  <= s2;
                fall  <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

module or_input_debouncer #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    // Channels share nothing but the clock and reset.
    or_input_debouncer_channel #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan_a (
        .clk  (clk),
        .rst  (rst),
        .raw  (a_raw),
        .level(a),
        .rise (a_rise),
        .fall (a_fall)
    );

    or_input_debouncer_channel #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan_b (
        .clk  (clk),
        .rst  (rst),
        .raw  (b_raw),
        .level(b),
        .rise (b_rise),
        .fall (b_fall)
    );

endmodule

// File: tb/tb_or_input_debouncer.sv
// Directed bench for or_input_debouncer at STABLE_CYCLES=4 (new level visible after edge 6).

module tb_or_input_debouncer;

    logic clk = 1'b0;
    logic rst;
    logic a_raw;
    logic b_raw;
    logic a;
    logic b;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;
    logic y;

    int vectors = 0;
    int miscompares = 0;

    or_input_debouncer #(
        .STABLE_CYCLES(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .a_raw (a_raw),
        .b_raw (b_raw),
        .a     (a),
        .b     (b),
        .a_rise(a_rise),
        .a_fall(a_fall),
        .b_rise(b_rise),
        .b_fall(b_fall)
    );

    // Downstream OR gate driven by the debounced levels.
    assign y = a | b;

    always #5 clk = ~clk;

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        a_raw = 1'b1;
        b_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({a, b, a_rise, a_fall, b_rise, b_fall} !== 6'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs cyc%0d: got %b want 000000", i,
                         {a, b, a_rise, a_fall, b_rise, b_fall});
            end
        end
        a_raw = 1'b0;
        b_raw = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if ({a, b} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: got %b want 00", {a, b});
        end
    endtask

    task automatic test_rise();
        a_raw = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            vectors++;
            if (a !== (e >= 6) || a_rise !== (e == 6) || a_fall !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rise_edge%0d: got a=%b rise=%b fall=%b want a=%b rise=%b fall=0",
                         e, a, a_rise, a_fall, (e >= 6), (e == 6));
            end
            vectors++;
            if ({b, b_rise, b_fall} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL rise_b_quiet%0d: got %b want 000", e, {b, b_rise, b_fall});
            end
        end
        a_raw = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            vectors++;
            if (a !== (e < 6) || a_fall !== (e == 6) || a_rise !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rise_return%0d: got a=%b fall=%b rise=%b want a=%b fall=%b rise=0",
                         e, a, a_fall, a_rise, (e < 6), (e == 6));
            end
        end
    endtask

    task automatic test_glitch();
        int rises = 0;
        b_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (b_rise === 1'b1) rises++;
        end
        b_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b_rise === 1'b1) rises++;
            vectors++;
            if (b !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL glitch_level%0d: got %b want 0", i, b);
            end
        end
        vectors++;
        if (rises !== 0) begin
            miscompares++;
            $display("[TB] FAIL glitch_rise_count: got %0d want 0", rises);
        end
    endtask

    task automatic test_simultaneous();
        a_raw = 1'b1;
        b_raw = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            vectors++;
            if ({a, b, a_rise, b_rise} !== ((e == 6) ? 4'b1111 : 4'b0000)) begin
                miscompares++;
                $display("[TB] FAIL simul_rise_edge%0d: got %b want %b", e,
                         {a, b, a_rise, b_rise}, ((e == 6) ? 4'b1111 : 4'b0000));
            end
        end
        vectors++;
        if (y !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL simul_or_y: got %b want 1", y);
        end
        a_raw = 1'b0;
        b_raw = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            vectors++;
            if ({a, b} !== ((e >= 6) ? 2'b00 : 2'b11) ||
                {a_fall, b_fall} !== ((e == 6) ? 2'b11 : 2'b00)) begin
                miscompares++;
                $display("[TB] FAIL simul_fall_edge%0d: got ab=%b falls=%b want ab=%b falls=%b", e,
                         {a, b}, {a_fall, b_fall}, ((e >= 6) ? 2'b00 : 2'b11),
                         ((e == 6) ? 2'b11 : 2'b00));
            end
        end
    endtask

    task automatic test_bounce();
        int rises = 0;
        for (int step = 0; step < 4; step++) begin
            a_raw = (step % 2 == 0);
            for (int i = 0; i < 2; i++) begin
                tick();
                if (a_rise === 1'b1) rises++;
                vectors++;
                if (a !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL bounce_hold_step%0d: got %b want 0", step, a);
                end
            end
        end
        a_raw = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (a_rise === 1'b1) rises++;
            vectors++;
            if (a !== (e >= 6) || a_rise !== (e == 6)) begin
                miscompares++;
                $display("[TB] FAIL bounce_settle_edge%0d: got a=%b rise=%b want a=%b rise=%b",
                         e, a, a_rise, (e >= 6), (e == 6));
            end
        end
        vectors++;
        if (rises !== 1) begin
            miscompares++;
            $display("[TB] FAIL bounce_rise_count: got %0d want 1", rises);
        end
        a_raw = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        vectors++;
        if (a !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bounce_release: got %b want 0", a);
        end
    endtask

    task automatic test_reset_mid_count();
        a_raw = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({a, a_rise} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL midrst_during: got %b want 00", {a, a_rise});
        end
        for (int e = 1; e <= 7; e++) begin
            tick();
            vectors++;
            if (a !== (e >= 6) || a_rise !== (e == 6)) begin
                miscompares++;
                $display("[TB] FAIL midrst_edge%0d: got a=%b rise=%b want a=%b rise=%b",
                         e, a, a_rise, (e >= 6), (e == 6));
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        a_raw = 1'b0;
        b_raw = 1'b0;
        test_reset();
        test_rise();
        test_glitch();
        test_simultaneous();
        test_bounce();
        test_reset_mid_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
